// File: rtl/alk_pkg.sv
// Shared definitions for the ALK shift-out / loop-control FUB.
// Optional feature macro used by this codebase slice: ALK_LOOP_EARLY_EXIT_EN.
package alk_pkg;

    // Loop counter width; the longest loop is 2**ALK_CNT_W steps.
    localparam int unsigned ALK_CNT_W = 5;

    // Loop sequencer states.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } alk_loop_state_e;

    // ALUSO next-value source select.
    localparam logic [1:0] ALUSO_SEL_HOLD = 2'b00;
    localparam logic [1:0] ALUSO_SEL_CLR  = 2'b01;
    localparam logic [1:0] ALUSO_SEL_SHL  = 2'b10;
    localparam logic [1:0] ALUSO_SEL_SHR  = 2'b11;

    // Priority encode the ALUSO source: clear, then left shift, then right shift.
    // Left shift wins over right shift so the illegal ucode combination is still deterministic.
    function automatic logic [1:0] aluso_sel(input logic clr, input logic shl, input logic shr);
        logic [1:0] sel;
        if (clr) begin
            sel = ALUSO_SEL_CLR;
        end else if (shl) begin
            sel = ALUSO_SEL_SHL;
        end else if (shr) begin
            sel = ALUSO_SEL_SHR;
        end else begin
            sel = ALUSO_SEL_HOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/alk_aluso_ff.sv
// ALUSO capture flip-flop: records the bit shifted out of the ALU each enabled microcycle.
module alk_aluso_ff
    import alk_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic step_en_i,
    input  logic clr_i,
    input  logic shl_op_i,
    input  logic shr_op_i,
    input  logic sout_shl_i,
    input  logic sout_shr_i,
    output logic aluso_o
);

    logic [1:0] sel;
    logic       aluso_d;
    logic       aluso_q;

    assign sel = aluso_sel(clr_i, shl_op_i, shr_op_i);

    // Select the next ALUSO value from the decoded source.
    always_comb begin
        aluso_d = aluso_q;
        unique case (sel)
            ALUSO_SEL_CLR:  aluso_d = 1'b0;
            ALUSO_SEL_SHL:  aluso_d = sout_shl_i;
            ALUSO_SEL_SHR:  aluso_d = sout_shr_i;
            default:        aluso_d = aluso_q;
        endcase
    end

    // Capture on enabled microcycles; stalls hold the flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            aluso_q <= 1'b0;
        end else if (step_en_i) begin
            aluso_q <= aluso_d;
        end
    end

    assign aluso_o = aluso_q;

endmodule

// File: rtl/alk_sout_loopctl.sv
// ALK shift-out flag and MUL/DIV loop controller.
// Produces ALUSO and LOOPF for the ALU shift-in mux and sequences iteration loops.
// Optional macro ALK_LOOP_EARLY_EXIT_EN: in multiply mode, q_rest_zero_h ends the loop early.
module alk_sout_loopctl
    import alk_pkg::*;
#(
    parameter int unsigned CNT_W = ALK_CNT_W
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             step_en_h,
    input  logic             alu_shl_op_h,
    input  logic             alu_shr_op_h,
    input  logic             alu_sout_shl_h,
    input  logic             alu_sout_shr_h,
    input  logic             aluso_clr_h,
    input  logic             loop_start_h,
    input  logic [CNT_W-1:0] loop_count_h,
    input  logic             alpctl_mul_l,
    input  logic             q_sout_shr_h,
    input  logic             q_rest_zero_h,
    output logic             aluso_h,
    output logic             loopf_h,
    output logic             loop_busy_h,
    output logic             loop_last_h,
    output logic             loop_done_h,
    output logic [CNT_W-1:0] loop_cnt_h
);

    alk_loop_state_e  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             loopf_q;
    logic             done_q;

    logic             mul_mode;
    logic             cnt_is_one;
    logic             early_exit;
    logic             last_step;

    alk_aluso_ff u_aluso_ff (
        .clk_i      (clk_h),
        .reset_i    (reset_h),
        .step_en_i  (step_en_h),
        .clr_i      (aluso_clr_h),
        .shl_op_i   (alu_shl_op_h),
        .shr_op_i   (alu_shr_op_h),
        .sout_shl_i (alu_sout_shl_h),
        .sout_shr_i (alu_sout_shr_h),
        .aluso_o    (aluso_h)
    );

    assign mul_mode   = ~alpctl_mul_l;
    assign cnt_is_one = (cnt_q == CNT_W'(1));

`ifdef ALK_LOOP_EARLY_EXIT_EN
    // No remaining multiplier bits: further add/shift steps cannot change the product.
    assign early_exit = mul_mode & q_rest_zero_h;
`else
    logic unused_q_rest_zero;
    assign unused_q_rest_zero = q_rest_zero_h;
    assign early_exit = 1'b0;
`endif

    // Final step of the loop, visible combinationally to microcode for branching.
    assign last_step = (state_q == StRun) & (cnt_is_one | early_exit);

    // Loop sequencer: count, multiplier-bit flag and done pulse, all gated by step_en_h.
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            loopf_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (step_en_h) begin
            done_q <= 1'b0;
            if (loop_start_h) begin
                // Start (or restart) wins over the last-step transition; no done pulse.
                state_q <= StRun;
                cnt_q   <= loop_count_h;
                loopf_q <= mul_mode & q_sout_shr_h;
            end else if (state_q == StRun) begin
                if (last_step) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    loopf_q <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    // A loaded zero wraps here, giving 2**CNT_W steps in total.
                    cnt_q   <= cnt_q - CNT_W'(1);
                    loopf_q <= mul_mode & q_sout_shr_h;
                end
            end
        end else begin
            // Stalled: everything holds except the done pulse, which is suppressed.
            done_q <= 1'b0;
        end
    end

    assign loopf_h     = loopf_q;
    assign loop_busy_h = (state_q == StRun);
    assign loop_last_h = last_step;
    assign loop_done_h = done_q;
    assign loop_cnt_h  = cnt_q;

endmodule
